// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: fetch FSM encoding and reset/bubble constants.
package mips_pkg;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StHold  = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, a load without a valid word inserts a bubble.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pcplus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pcplus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (flush_i || (!stall_i && !valid_i)) begin
            instr_d = NOP_INSTR;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            instr_d = instr_i;
            pcp4_d  = pcplus4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pcp4_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcp4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PCF, next-PC select, req/ack instruction-memory handshake with a one-word skid
// buffer for stalls, and redirect draining so an outstanding request is never abandoned.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pcnext,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pcp4_q, skid_pcp4_d;
    logic         skid_valid_q, skid_valid_d;

    logic [31:0]  seq_pc;
    logic         redirect;
    logic         id_drain;
    logic         id_load;
    logic [31:0]  id_instr, id_pcp4;
    logic         req_raw;

    assign seq_pc    = pc_q + 32'd4;
    assign redirect  = (JumpD | PCSrcD) & ~StallD;
    assign pcnext    = JumpD ? PCJumpD : (PCSrcD ? PCBranchD : seq_pc);
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign imem_req  = req_raw & ~reset;
    // A flushed IF/ID must not swallow the skid word, so draining waits for a clean load.
    assign id_drain  = skid_valid_q & ~StallD & ~FlushD;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        skid_instr_d = skid_instr_q;
        skid_pcp4_d  = skid_pcp4_q;
        skid_valid_d = skid_valid_q;
        id_load      = 1'b0;
        id_instr     = skid_instr_q;
        id_pcp4      = skid_pcp4_q;
        req_raw      = 1'b0;
        FetchBusy    = 1'b0;

        unique case (state_q)
            StFetch: begin
                req_raw   = 1'b1;
                FetchBusy = ~imem_ack;
                if (redirect) begin
                    // Any word arriving now is wrong-path fall-through.
                    skid_valid_d = 1'b0;
                    if (imem_ack) begin
                        pc_d = pcnext;
                    end else begin
                        target_d = pcnext;
                        state_d  = StDrain;
                    end
                end else begin
                    if (id_drain) begin
                        id_load      = 1'b1;
                        skid_valid_d = 1'b0;
                    end
                    if (imem_ack) begin
                        if (StallF) begin
                            skid_valid_d = 1'b1;
                            skid_instr_d = imem_rdata;
                            skid_pcp4_d  = seq_pc;
                            state_d      = StHold;
                        end else begin
                            pc_d = pcnext;
                            if (!StallD && !skid_valid_q) begin
                                id_load  = 1'b1;
                                id_instr = imem_rdata;
                                id_pcp4  = seq_pc;
                            end else begin
                                skid_valid_d = 1'b1;
                                skid_instr_d = imem_rdata;
                                skid_pcp4_d  = seq_pc;
                            end
                        end
                    end
                end
            end
            StHold: begin
                if (redirect) begin
                    skid_valid_d = 1'b0;
                    pc_d         = pcnext;
                    state_d      = StFetch;
                end else begin
                    if (id_drain) begin
                        id_load      = 1'b1;
                        skid_valid_d = 1'b0;
                    end
                    if (!StallF) begin
                        pc_d    = pcnext;
                        state_d = StFetch;
                    end
                end
            end
            StDrain: begin
                req_raw   = 1'b1;
                FetchBusy = 1'b1;
                if (imem_ack) begin
                    pc_d    = redirect ? pcnext : target_q;
                    state_d = StFetch;
                end else if (redirect) begin
                    target_d = pcnext;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            target_q     <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_pcp4_q  <= 32'd0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            skid_instr_q <= skid_instr_d;
            skid_pcp4_q  <= skid_pcp4_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .stall_i   (StallD),
        .flush_i   (FlushD),
        .valid_i   (id_load),
        .instr_i   (id_instr),
        .pcplus4_i (id_pcp4),
        .instr_o   (InstrD),
        .pcplus4_o (PCPlus4D),
        .valid_o   (ValidD)
    );

endmodule
